// File: rtl/alu_pkg.sv
// Shared definitions for the ALU sharing arbiter: operand width, op codes and port ids.
package alu_pkg;

   localparam int DEF_WIDTH = 64;

   typedef logic [1:0] alu_op_t;

   localparam alu_op_t ALU_ADD = 2'b00;
   localparam alu_op_t ALU_SUB = 2'b01;
   localparam alu_op_t ALU_AND = 2'b10;
   localparam alu_op_t ALU_OR  = 2'b11;

   localparam logic PORT0 = 1'b0;
   localparam logic PORT1 = 1'b1;

   // Port that wins the first contention after reset is the one not granted last.
   localparam logic LAST_GRANT_RST = PORT1;

endpackage

// File: rtl/alu_core.sv
// Single shared ALU datapath: combinational ADD/SUB/AND/OR with zero flag.
module alu_core
   import alu_pkg::*;
#(
   parameter int WIDTH = DEF_WIDTH
) (
   input  alu_op_t          op,
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   output logic [WIDTH-1:0] result,
   output logic             zero
);

   logic [WIDTH-1:0] and_res;
   logic [WIDTH-1:0] or_res;

   assign and_res = a & b;
   assign or_res  = a | b;

   // Carry/borrow out is intentionally dropped; results wrap.
   always_comb begin
      result = '0;
      case (op)
         ALU_ADD: result = a + b;
         ALU_SUB: result = a - b;
         ALU_AND: result = and_res;
         default: result = or_res;
      endcase
   end

   assign zero = ~|result;

endmodule

// File: rtl/alu_share_arbiter.sv
// Round-robin share of one ALU between two requesters, with a registered valid/ready result.
module alu_share_arbiter
   import alu_pkg::*;
#(
   parameter int WIDTH = DEF_WIDTH
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             req0_valid,
   output logic             req0_ready,
   input  alu_op_t          req0_op,
   input  logic [WIDTH-1:0] req0_a,
   input  logic [WIDTH-1:0] req0_b,
   input  logic             req1_valid,
   output logic             req1_ready,
   input  alu_op_t          req1_op,
   input  logic [WIDTH-1:0] req1_a,
   input  logic [WIDTH-1:0] req1_b,
   output logic             rsp_valid,
   input  logic             rsp_ready,
   output logic             rsp_id,
   output logic [WIDTH-1:0] rsp_result,
   output logic             rsp_zero
);

   logic             last_grant;
   logic             can_accept;
   logic             gnt_any;
   logic             gnt_id;
   logic             accept;
   alu_op_t          alu_op;
   logic [WIDTH-1:0] alu_a;
   logic [WIDTH-1:0] alu_b;
   logic [WIDTH-1:0] alu_res;
   logic             alu_zero;

   assign can_accept = !rsp_valid || rsp_ready;
   assign gnt_any    = req0_valid || req1_valid;

   // Contention goes to the port not granted last; otherwise whoever is valid.
   assign gnt_id = (req0_valid && req1_valid) ? ~last_grant : req1_valid;

   assign accept     = can_accept && gnt_any && !reset;
   assign req0_ready = accept && (gnt_id == PORT0);
   assign req1_ready = accept && (gnt_id == PORT1);

   assign alu_op = (gnt_id == PORT1) ? req1_op : req0_op;
   assign alu_a  = (gnt_id == PORT1) ? req1_a  : req0_a;
   assign alu_b  = (gnt_id == PORT1) ? req1_b  : req0_b;

   alu_core #(.WIDTH(WIDTH)) u_alu (
      .op     (alu_op),
      .a      (alu_a),
      .b      (alu_b),
      .result (alu_res),
      .zero   (alu_zero)
   );

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         rsp_valid  <= 1'b0;
         rsp_id     <= PORT0;
         rsp_result <= '0;
         rsp_zero   <= 1'b1;
         last_grant <= LAST_GRANT_RST;
      end else if (accept) begin
         rsp_valid  <= 1'b1;
         rsp_id     <= gnt_id;
         rsp_result <= alu_res;
         rsp_zero   <= alu_zero;
         last_grant <= gnt_id;
      end else if (rsp_ready) begin
         rsp_valid  <= 1'b0;
      end
   end

endmodule

// File: tb/tb_alu_share_arbiter.sv
// Directed plus randomized check of alu_share_arbiter against a cycle-level reference model.
module tb_alu_share_arbiter;

   localparam int W = 64;

   logic         clk = 1'b0;
   logic         reset;
   logic         req0_valid, req0_ready, req1_valid, req1_ready;
   logic [1:0]   req0_op, req1_op;
   logic [W-1:0] req0_a, req0_b, req1_a, req1_b;
   logic         rsp_valid, rsp_ready, rsp_id, rsp_zero;
   logic [W-1:0] rsp_result;

   int n_vec = 0;
   int n_err = 0;

   // reference state: what the consumer should see, and who has priority next contention
   bit           m_valid;
   bit           m_id;
   logic [W-1:0] m_result;
   int           m_prio;
   int           last_acc;

   always #5 clk = ~clk;

   alu_share_arbiter #(.WIDTH(W)) dut (
      .clk(clk), .reset(reset),
      .req0_valid(req0_valid), .req0_ready(req0_ready), .req0_op(req0_op),
      .req0_a(req0_a), .req0_b(req0_b),
      .req1_valid(req1_valid), .req1_ready(req1_ready), .req1_op(req1_op),
      .req1_a(req1_a), .req1_b(req1_b),
      .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_id(rsp_id),
      .rsp_result(rsp_result), .rsp_zero(rsp_zero)
   );

   task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
      n_vec++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s: got %h expected %h", tag, got, exp);
      end
   endtask

   function automatic logic [W-1:0] alu_ref(input logic [1:0] op, input logic [W-1:0] a,
                                            input logic [W-1:0] b);
      case (op)
         2'd0:    return a + b;
         2'd1:    return a - b;
         2'd2:    return a & b;
         default: return a | b;
      endcase
   endfunction

   task automatic check_rsp(input string tag);
      chk({tag, ".valid"}, 64'(rsp_valid), 64'(m_valid));
      chk({tag, ".id"}, 64'(rsp_id), 64'(m_id));
      chk({tag, ".result"}, rsp_result, m_result);
      chk({tag, ".zero"}, 64'(rsp_zero), 64'(m_result == '0));
   endtask

   task automatic set0(input bit v, input logic [1:0] op, input logic [W-1:0] a, input logic [W-1:0] b);
      req0_valid = v; req0_op = op; req0_a = a; req0_b = b;
   endtask

   task automatic set1(input bit v, input logic [1:0] op, input logic [W-1:0] a, input logic [W-1:0] b);
      req1_valid = v; req1_op = op; req1_a = a; req1_b = b;
   endtask

   // One clock: check readies mid-cycle, advance model at the edge, check result after it.
   task automatic step(input string tag);
      int  g;
      bit  can;
      @(negedge clk);
      g = -1;
      if (req0_valid && req1_valid) g = m_prio;
      else if (req0_valid)          g = 0;
      else if (req1_valid)          g = 1;
      can = !m_valid || rsp_ready;
      chk({tag, ".rdy0"}, 64'(req0_ready), 64'(can && g == 0));
      chk({tag, ".rdy1"}, 64'(req1_ready), 64'(can && g == 1));
      @(posedge clk);
      last_acc = -1;
      if (can && g >= 0) begin
         m_valid  = 1'b1;
         m_id     = (g == 1);
         m_result = (g == 1) ? alu_ref(req1_op, req1_a, req1_b) : alu_ref(req0_op, req0_a, req0_b);
         m_prio   = 1 - g;
         last_acc = g;
      end else if (rsp_ready) begin
         m_valid = 1'b0;
      end
      #1;
      check_rsp(tag);
   endtask

   // Called just after a rising edge; reset takes effect without waiting for a clock.
   task automatic do_reset(input string tag);
      reset = 1'b1;
      #1;
      m_valid = 1'b0; m_id = 1'b0; m_result = '0; m_prio = 0;
      check_rsp(tag);
      chk({tag, ".rdy0"}, 64'(req0_ready), 64'd0);
      chk({tag, ".rdy1"}, 64'(req1_ready), 64'd0);
      #2;
      reset = 1'b0;
   endtask

   function automatic logic [W-1:0] rnd_operand();
      case ($urandom_range(0, 5))
         0:       return '0;
         1:       return '1;
         2:       return 64'd1;
         default: return {$urandom, $urandom};
      endcase
   endfunction

   initial begin
      reset = 1'b1;
      rsp_ready = 1'b0;
      set0(1'b1, 2'd0, 64'd5, 64'd6);
      set1(1'b1, 2'd0, 64'd7, 64'd8);
      @(posedge clk);
      #1;
      do_reset("rst");
      set0(1'b0, 2'd0, '0, '0);
      set1(1'b0, 2'd0, '0, '0);

      // OR from port 0
      rsp_ready = 1'b1;
      set0(1'b1, 2'b11, 64'hFFFF_FFFF_FFFF_FFFF, 64'hAAAA_AAAA_AAAA_AAAA);
      step("or0");
      chk("or0.const", rsp_result, 64'hFFFF_FFFF_FFFF_FFFF);
      set0(1'b0, 2'd0, '0, '0);

      // continuous contention from a fresh reset alternates 0,1,0,1
      do_reset("rst2");
      set0(1'b1, 2'b00, 64'd1, 64'd1);
      set1(1'b1, 2'b10, 64'hDB6D_B6DB_6DB6_DB6D, 64'hAAAA_AAAA_AAAA_AAAA);
      for (int i = 0; i < 4; i++) begin
         step("rr");
         chk("rr.id", 64'(rsp_id), 64'(i % 2));
         chk("rr.res", rsp_result, (i % 2) ? 64'h8A28_A28A_28A2_8A28 : 64'd2);
      end
      set0(1'b0, 2'd0, '0, '0);
      set1(1'b0, 2'd0, '0, '0);
      step("idle");

      // SUB held under backpressure
      rsp_ready = 1'b0;
      set0(1'b1, 2'b01, 64'd0, 64'd1);
      step("sub");
      set0(1'b0, 2'd0, '0, '0);
      for (int i = 0; i < 3; i++) begin
         step("hold");
         chk("hold.res", rsp_result, 64'hFFFF_FFFF_FFFF_FFFF);
      end
      rsp_ready = 1'b1;
      step("drain");

      // drain and accept in the same edge
      rsp_ready = 1'b0;
      set0(1'b1, 2'b00, 64'd3, 64'd4);
      step("pend");
      set0(1'b0, 2'd0, '0, '0);
      rsp_ready = 1'b1;
      set1(1'b1, 2'b11, '0, '0);
      step("b2b");
      chk("b2b.zero", 64'(rsp_zero), 64'd1);
      set1(1'b0, 2'd0, '0, '0);

      // reset with a result pending and both ports asking
      rsp_ready = 1'b0;
      set0(1'b1, 2'b00, 64'd9, 64'd9);
      set1(1'b1, 2'b01, 64'd9, 64'd2);
      step("pre_rst");
      do_reset("midrst");
      rsp_ready = 1'b1;
      step("post_rst");
      chk("post_rst.id", 64'(rsp_id), 64'd0);
      set0(1'b0, 2'd0, '0, '0);

      // wraparound from port 1 (its request is still pending from above)
      step("p1");
      set1(1'b1, 2'b00, 64'hFFFF_FFFF_FFFF_FFFF, 64'd1);
      step("wrap");
      chk("wrap.res", rsp_result, 64'd0);
      set1(1'b0, 2'd0, '0, '0);
      step("idle2");

      // randomized traffic obeying the hold-until-ready rule
      for (int c = 0; c < 400; c++) begin
         if (last_acc == 0) req0_valid = 1'b0;
         if (last_acc == 1) req1_valid = 1'b0;
         if (!req0_valid && $urandom_range(0, 2) != 0)
            set0(1'b1, 2'($urandom_range(0, 3)), rnd_operand(), rnd_operand());
         if (!req1_valid && $urandom_range(0, 2) != 0)
            set1(1'b1, 2'($urandom_range(0, 3)), rnd_operand(), rnd_operand());
         rsp_ready = ($urandom_range(0, 3) != 0);
         step("rnd");
      end

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule

// File: doc/alu_share_arbiter.md
# alu_share_arbiter

Shares the sequential processor's single 64-bit ALU datapath (ADD/SUB/AND/OR) between two requesters: port 0, the main execute sequencer, and port 1, the branch/address unit. Each cycle the arbiter grants at most one request by round-robin, computes the result through one ALU instance and holds it in an output register with a valid/ready handshake until the consumer accepts it. The block sits between the control FSM and the ALU so that no second 64-bit adder is needed.

## Interface
- WIDTH, 64, operand and result width
- clk  in  1  rising-edge clock
- reset  in  1  asynchronous, active-high reset
- req0_valid  in  1  port 0 request present
- req0_ready  out  1  port 0 request accepted this cycle
- req0_op  in  2  port 0 operation code
- req0_a, req0_b  in  WIDTH  port 0 operands
- req1_valid, req1_ready, req1_op, req1_a, req1_b  same as port 0, for port 1
- rsp_valid  out  1  result register holds a valid result
- rsp_ready  in  1  consumer accepts the result
- rsp_id  out  1  requester that owns the result (0 or 1)
- rsp_result  out  WIDTH  ALU result
- rsp_zero  out  1  high when rsp_result == 0

## Operation
- Op codes: 2'b00 ADD (a+b), 2'b01 SUB (a−b), 2'b10 AND, 2'b11 OR. ADD/SUB wrap modulo 2^WIDTH and carry/borrow is discarded.
- The arbiter can accept a request when `can_accept = !rsp_valid || rsp_ready`.
- Grant:
  - only one port valid → that port;
  - both valid → the port not granted last (`last_grant` register);
  - none valid → no grant.
- `reqN_ready = can_accept && grant==N`. Ready never depends on the ungranted port's valid.
- On an accepted request:
  - rsp_result ← ALU(op, a, b);
  - rsp_id ← N;
  - rsp_valid ← 1;
  - last_grant ← N.
- On `rsp_valid && rsp_ready` with no new accept: rsp_valid ← 0. rsp_result and rsp_id keep their last value.
- Simultaneous drain and accept: the new result replaces the old one in the same edge and rsp_valid stays 1.
- While `rsp_valid && !rsp_ready`, rsp_result, rsp_id and rsp_zero are stable, and both req ready outputs are 0.
- last_grant updates only on an accept. An idle cycle does not change fairness state.
- Operands and op are sampled only on the accepting edge. Changes to them while ready=0 have no effect.

## Timing
- Reset values:
  - rsp_valid=0, rsp_id=0, rsp_result=0, rsp_zero=1;
  - last_grant=1, so port 0 wins the first contention;
  - req0_ready=0, req1_ready=0 (combinational, forced low while reset is asserted).
- Latency: a request accepted at edge T shows rsp_valid=1 with its result after edge T. This is one cycle.
- Throughput: one result per cycle while rsp_ready stays high.
- Fairness: under continuous contention, grants alternate 0,1,0,1. Neither port waits more than one accept.
- Reset asserted mid-operation clears rsp_valid immediately (asynchronously). Any pending result is dropped and not replayed. last_grant returns to 1.
- Requester rule: once reqN_valid is raised, it stays high with stable op/a/b until reqN_ready. The arbiter does not check this.

## Structure
- Shared package `alu_pkg`:
  - op-code localparams ALU_ADD, ALU_SUB, ALU_AND, ALU_OR;
  - WIDTH default 64;
  - port-id constants.
- Sub-module `alu_core`: purely combinational, inputs op, a, b; outputs result and zero. It reuses the existing 64-bit AND/OR gate blocks for the logic ops. It is instantiated once, fed by the grant mux.
- Top level contains the grant logic, the last_grant flop and the output register. There is no FSM beyond the rsp_valid / last_grant state bits.

## Test plan
- Reset, then port 0 issues OR with a=64'hFFFF_FFFF_FFFF_FFFF, b=64'hAAAA_AAAA_AAAA_AAAA, rsp_ready=1 → next cycle rsp_valid=1, rsp_id=0, rsp_result=64'hFFFF_FFFF_FFFF_FFFF, rsp_zero=0.
- Both ports valid for 4 cycles (port 0: ADD 1+1; port 1: AND 0xDB6D…6D & 0xAAAA…AA), rsp_ready=1 → rsp_id sequence 0,1,0,1; results 2 and 64'h8A28_A28A_28A2_8A28 respectively.
- Port 0 SUB 0−1 with rsp_ready=0 for 3 cycles → rsp_result=64'hFFFF_FFFF_FFFF_FFFF held stable, req0_ready=req1_ready=0; rsp_ready=1 → rsp_valid drops next cycle.
- Back-to-back accept during drain: result pending, rsp_ready=1, port 1 OR 0|0 valid same cycle → rsp_valid stays 1, rsp_result=0, rsp_zero=1, rsp_id=1.
- Assert reset while rsp_valid=1 and both ports valid → rsp_valid=0 immediately. After release, the first contention grants port 0.
- Port 1 ADD 64'hFFFF_FFFF_FFFF_FFFF + 1 → rsp_result=0, rsp_zero=1 (wrap, carry dropped).
